sega_joy_reader: RTL and testbench
==================================

Name: sega_joy_reader

Overview:
- Upstream input stage for the arcade top level. It scans two DB9 joystick ports by driving the shared select line (pin 7) through a fixed step sequence.
- It detects Master System 2-button, Mega Drive 3-button and Mega Drive 6-button pads per port.
- It publishes coherent, active-low 12-bit button words in MXYZ SACB RLDU order to the game input mux.
- The game input mux combines these words with the keyboard joystick output.

Parameters:
- TICK_DIV, 1536: clk_i cycles per scan step (about 64 us at 24 MHz). Must be >= 4.
- STEP_BITS, 8: width of the step counter. One scan frame is 2**STEP_BITS steps.

Ports:
- clk_i  in  1  system clock.
- res_n_i  in  1  asynchronous active-low reset.
- joy1_pins_i  in  6  port 1 raw pins {p9,p6,right,left,down,up}, active low, asynchronous.
- joy2_pins_i  in  6  port 2 raw pins, same layout.
- joy_p7_o  out  1  shared select line driven to both ports.
- joy1_o  out  12  port 1 word {M,X,Y,Z,S,A,C,B,R,L,D,U}, active low.
- joy2_o  out  12  port 2 word, same layout.
- six1_o  out  1  port 1 is a 6-button pad (active high).
- six2_o  out  1  port 2 is a 6-button pad (active high).
- frame_o  out  1  one-cycle strobe when all outputs update.

Behaviour:
- Reset (async assert, sync release):
  - joy1_o/joy2_o = 12'hFFF; joy_p7_o = 1; six1_o/six2_o = 0; frame_o = 0.
  - Prescaler, step counter, staging registers and synchronizers all cleared; synchronizers reset to all-ones.
- Input synchronization: every pin passes a 2-flop synchronizer. All decisions below use the synchronized values.
- Prescaler: counts 0..TICK_DIV-1. A one-cycle tick is asserted at terminal count, then the prescaler wraps to 0.
- Step counter: increments on each tick and wraps from 2**STEP_BITS-1 to 0. All actions below occur on the tick cycle, using the current step value before the increment.
- Step 0: p7 <= 0.
- Step 1: p7 <= 1.
- Step 2: p7 <= 0; sixN <= 0 in staging. Stage[3:0] <= {R,L,D,U}; stage[5:4] <= {p9,p6} (C,B).
- Step 3: p7 <= 1. Per port:
  - If synchronized R=0 and L=0 (Mega Drive): stage[7:6] <= {p9,p6} (Start,A).
  - Otherwise (Master System): stage[7:4] <= {1,1,p9,p6}.
- Step 4: p7 <= 0.
- Step 5: p7 <= 1. Per port, if R, L, D and U are all 0: staged six <= 1.
- Step 6: p7 <= 0. Per port:
  - If staged six=1: stage[11:8] <= {R,L,D,U} (M,X,Y,Z).
  - Otherwise: stage[11:8] <= 4'hF.
- Step 7:
  - p7 <= 1.
  - joyN_o <= stage; sixN_o <= staged six; frame_o = 1 for exactly this cycle.
  - Outputs change only here, so a frame is never torn.
- Steps 8..2**STEP_BITS-1: p7 held at 1. This idle period lets the 6-button pad's internal counter time out before the next frame.
- joy_p7_o is registered; it changes only on tick cycles.
- Boundary conditions:
  - No pad connected (pins pulled high): word stays 12'hFFF and six=0.
  - Mid-frame reset: outputs return to reset values immediately. Scanning restarts at step 0 after release; the first frame_o occurs 8 ticks after release.
  - A port changing pad type between frames takes effect at the next step 7.
  - Both ports are evaluated independently within the same step.

Decomposition:
- Package sega_joy_pkg holds:
  - step constants STEP_SEL_LO0=0 through STEP_PUBLISH=7;
  - bit-index constants for the U,D,L,R,B,C,A,S,Z,Y,X,M fields;
  - typedef joy_word_t (logic [11:0]);
  - localparam JOY_IDLE = 12'hFFF.
- One sub-module: sync2 (parameterized-width 2-flop synchronizer with async active-low reset and all-ones reset value). Instantiate it once per port.
- Per-port staging logic is a generate loop over two ports, not a separate module.

Test Plan:
- Reset release with all pins high, TICK_DIV=4: frame_o first pulses 8 ticks (32 cycles) after release. joy1_o = joy2_o = 12'hFFF, six1_o = six2_o = 0. joy_p7_o sequence is 1,0,1,0,1,0,1,0,1,1...
- Master System model on port 1 with up and B pressed: joy1_o = 12'hFEE (1111_1110_1110), six1_o=0.
- 3-button MD model on port 2 (L,R forced low when p7=0) with Start and A pressed: joy2_o bits[7:6] = 00, bits[11:8] = F, six2_o=0.
- 6-button MD model on port 1 (third low phase drives all dirs low) with X and Mode pressed: six1_o=1 and joy1_o[11:8] = 4'b0011 (M,X low).
- Pad pins toggled at step 4 of a frame: joy1_o unchanged until that frame's step-7 strobe. The value is then coherent with the staged samples and never partially updated.
- Assert res_n_i at step 5 after a 6-button frame: six1_o and joy1_o return to 0 and 12'hFFF asynchronously, and joy_p7_o = 1. The sequence restarts cleanly at step 0.

Source files
------------

// File: rtl/sega_joy_pkg.sv
// Shared constants and types for the DB9 Sega pad scanner.
// Step numbers name what each tick of the scan frame does.
package sega_joy_pkg;

  // Scan frame step numbers
  localparam int STEP_SEL_LO0    = 0;
  localparam int STEP_SEL_HI0    = 1;
  localparam int STEP_SAMPLE_HI  = 2;
  localparam int STEP_SAMPLE_LO  = 3;
  localparam int STEP_SEL_LO2    = 4;
  localparam int STEP_DETECT6    = 5;
  localparam int STEP_SAMPLE_EXT = 6;
  localparam int STEP_PUBLISH    = 7;

  // Button word bit positions, MXYZ SACB RLDU
  localparam int BIT_U = 0;
  localparam int BIT_D = 1;
  localparam int BIT_L = 2;
  localparam int BIT_R = 3;
  localparam int BIT_B = 4;
  localparam int BIT_C = 5;
  localparam int BIT_A = 6;
  localparam int BIT_S = 7;
  localparam int BIT_Z = 8;
  localparam int BIT_Y = 9;
  localparam int BIT_X = 10;
  localparam int BIT_M = 11;

  typedef logic [11:0] joy_word_t;

  localparam joy_word_t JOY_IDLE = 12'hFFF;

  // Select-line level set on the tick of a given step: toggles through the
  // first eight steps, then held high for the rest of the frame.
  function automatic logic sel_level(input int step);
    return (step > STEP_PUBLISH) || ((step % 2) == 1);
  endfunction

endpackage

// File: rtl/sega_joy_reader_sync2.sv
// Two-flop synchronizer for asynchronous active-low pad pins.
// Resets to all-ones so an unsynchronized pin reads as released.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sega_joy_reader.sv
// Scans two DB9 Sega pad ports via the shared select line and publishes
// coherent active-low 12-bit button words once per scan frame.
module sega_joy_reader
  import sega_joy_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1536,
  parameter int unsigned STEP_BITS = 8
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic [5:0]  joy1_pins_i,
  input  logic [5:0]  joy2_pins_i,
  output logic        joy_p7_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        frame_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(TICK_DIV - 1);

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [STEP_BITS-1:0] step_q, step_d;
  logic                 p7_q, p7_d;
  logic                 frame_q, frame_d;
  logic                 tick;
  int                   step_int;

  logic [5:0] pins_raw  [2];
  logic [5:0] pins_sync [2];

  assign pins_raw[0] = joy1_pins_i;
  assign pins_raw[1] = joy2_pins_i;

  assign step_int = int'(step_q);

  always_comb begin
    tick    = (cnt_q == TermCnt);
    cnt_d   = tick ? '0 : cnt_q + CntW'(1);
    step_d  = tick ? step_q + STEP_BITS'(1) : step_q;
    p7_d    = tick ? sel_level(step_int) : p7_q;
    frame_d = tick && (step_int == STEP_PUBLISH);
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      cnt_q   <= '0;
      step_q  <= '0;
      p7_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      p7_q    <= p7_d;
      frame_q <= frame_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_port
    joy_word_t  stage_q, stage_d;
    joy_word_t  word_q;
    logic       six_stage_q, six_stage_d;
    logic       six_q;
    logic [5:0] pins;

    sync2 #(
      .WIDTH (6)
    ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (res_n_i),
      .d_i    (pins_raw[g]),
      .q_o    (pins_sync[g])
    );

    // pins = {p9, p6, right, left, down, up}
    assign pins = pins_sync[g];

    always_comb begin
      stage_d     = stage_q;
      six_stage_d = six_stage_q;
      if (tick) begin
        case (step_int)
          STEP_SAMPLE_HI: begin
            stage_d[BIT_C:BIT_U] = pins;
            six_stage_d          = 1'b0;
          end
          STEP_SAMPLE_LO: begin
            // Right and left both low while select is low marks a Mega Drive pad
            if (!pins[3] && !pins[2]) begin
              stage_d[BIT_S:BIT_A] = pins[5:4];
            end else begin
              stage_d[BIT_S:BIT_B] = {2'b11, pins[5:4]};
            end
          end
          STEP_DETECT6: begin
            if (pins[3:0] == 4'h0) begin
              six_stage_d = 1'b1;
            end
          end
          STEP_SAMPLE_EXT: begin
            stage_d[BIT_M:BIT_Z] = six_stage_q ? pins[3:0] : 4'hF;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
        stage_q     <= JOY_IDLE;
        six_stage_q <= 1'b0;
        word_q      <= JOY_IDLE;
        six_q       <= 1'b0;
      end else begin
        stage_q     <= stage_d;
        six_stage_q <= six_stage_d;
        if (frame_d) begin
          word_q <= stage_q;
          six_q  <= six_stage_q;
        end
      end
    end
  end

  assign joy_p7_o = p7_q;
  assign frame_o  = frame_q;
  assign joy1_o   = g_port[0].word_q;
  assign joy2_o   = g_port[1].word_q;
  assign six1_o   = g_port[0].six_q;
  assign six2_o   = g_port[1].six_q;

endmodule

// File: tb/tb_sega_joy_reader.sv
// Directed bench for sega_joy_reader with behavioural pad models on both ports.
module tb_sega_joy_reader;

  localparam int unsigned TickDiv = 4;

  logic        clk_i = 1'b0;
  logic        res_n_i;
  logic [5:0]  joy1_pins_i, joy2_pins_i;
  logic        joy_p7_o;
  logic [11:0] joy1_o, joy2_o;
  logic        six1_o, six2_o, frame_o;

  int n_cmp = 0;
  int n_err = 0;

  // Pad types: 0 none, 1 Master System, 2 MD 3-button, 3 MD 6-button
  int          t1, t2;
  logic [11:0] b1, b2;
  logic [3:0]  phase;
  logic        p7_prev;
  int          idle;

  sega_joy_reader #(
    .TICK_DIV  (TickDiv),
    .STEP_BITS (8)
  ) dut (
    .clk_i       (clk_i),
    .res_n_i     (res_n_i),
    .joy1_pins_i (joy1_pins_i),
    .joy2_pins_i (joy2_pins_i),
    .joy_p7_o    (joy_p7_o),
    .joy1_o      (joy1_o),
    .joy2_o      (joy2_o),
    .six1_o      (six1_o),
    .six2_o      (six2_o),
    .frame_o     (frame_o)
  );

  always #5 clk_i = ~clk_i;

  // Select phase count since the pad last timed out (long high idle)
  always @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      phase   <= 4'd0;
      p7_prev <= 1'b1;
      idle    <= 0;
    end else begin
      p7_prev <= joy_p7_o;
      if (joy_p7_o != p7_prev) begin
        if (phase != 4'hF) phase <= phase + 4'd1;
        idle <= 0;
      end else if (joy_p7_o) begin
        if (idle >= 20) phase <= 4'd0;
        else idle <= idle + 1;
      end
    end
  end

  function automatic logic [5:0] pad_pins(input int t, input logic [11:0] b, input logic p7,
                                          input logic [3:0] ph);
    logic [5:0] r;
    case (t)
      1: r = b[5:0];
      2: r = p7 ? b[5:0] : {b[7:6], 2'b00, b[1:0]};
      3: begin
        if (p7) r = (ph == 4'd6) ? {b[5:4], b[11:8]} : b[5:0];
        else if (ph == 4'd5) r = {b[7:6], 4'h0};
        else if (ph == 4'd7) r = {b[7:6], 4'hF};
        else r = {b[7:6], 2'b00, b[1:0]};
      end
      default: r = 6'h3F;
    endcase
    return r;
  endfunction

  always_comb begin
    joy1_pins_i = pad_pins(t1, b1, joy_p7_o, phase);
    joy2_pins_i = pad_pins(t2, b2, joy_p7_o, phase);
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_i);
      if (frame_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("frame_seen", 12'(seen), 12'd1);
  endtask

  typedef struct {
    int          t1;
    logic [11:0] b1;
    int          t2;
    logic [11:0] b2;
    logic [11:0] e1;
    logic        s1;
    logic [11:0] e2;
    logic        s2;
  } vec_t;

  vec_t vecs[5];
  int   p7_seq[10];

  initial begin
    p7_seq = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    //          t1  b1       t2  b2       exp1     six1  exp2     six2
    vecs[0] = '{0, 12'hFFF, 0, 12'hFFF, 12'hFFF, 1'b0, 12'hFFF, 1'b0};
    vecs[1] = '{1, 12'hFEE, 2, 12'hF3F, 12'hFEE, 1'b0, 12'hF3F, 1'b0};
    vecs[2] = '{3, 12'h3FF, 1, 12'hFDB, 12'h3FF, 1'b1, 12'hFDB, 1'b0};
    vecs[3] = '{2, 12'hFE0, 3, 12'hC97, 12'h0E0, 1'b1, 12'hC97, 1'b1};
    vecs[4] = '{1, 12'h000, 0, 12'hFFF, 12'h000, 1'b1, 12'hFFF, 1'b0};

    res_n_i = 1'b0;
    t1 = 0; t2 = 0; b1 = 12'hFFF; b2 = 12'hFFF;
    repeat (3) @(negedge clk_i);
    chk("rst_joy1", joy1_o, 12'hFFF);
    chk("rst_joy2", joy2_o, 12'hFFF);
    chk("rst_six1", 12'(six1_o), 12'd0);
    chk("rst_six2", 12'(six2_o), 12'd0);
    chk("rst_p7", 12'(joy_p7_o), 12'd1);
    chk("rst_frame", 12'(frame_o), 12'd0);

    res_n_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("p7_step%0d", k), 12'(joy_p7_o), 12'(p7_seq[k]));
      chk($sformatf("frame_step%0d", k), 12'(frame_o), 12'(k == 8));
      if (k == 8) begin
        chk("idle_joy1", joy1_o, 12'hFFF);
        chk("idle_six1", 12'(six1_o), 12'd0);
      end
      if (k < 9) repeat (TickDiv) @(negedge clk_i);
    end

    for (int v = 0; v < 5; v++) begin
      t1 = vecs[v].t1; b1 = vecs[v].b1;
      t2 = vecs[v].t2; b2 = vecs[v].b2;
      wait_frame();
      chk($sformatf("v%0d_joy1", v), joy1_o, vecs[v].e1);
      chk($sformatf("v%0d_six1", v), 12'(six1_o), 12'(vecs[v].s1));
      chk($sformatf("v%0d_joy2", v), joy2_o, vecs[v].e2);
      chk($sformatf("v%0d_six2", v), 12'(six2_o), 12'(vecs[v].s2));
    end

    // Pad buttons change at step 4; output must hold until the frame strobe
    t1 = 3; b1 = 12'h3FF; t2 = 0;
    wait_frame();
    chk("pre_joy1", joy1_o, 12'h3FF);
    b1 = 12'h3DE;
    repeat (253 * TickDiv) @(posedge clk_i);
    #1 b1 = 12'hFFF;
    repeat (6) @(negedge clk_i);
    chk("hold_joy1", joy1_o, 12'h3FF);
    chk("hold_frame", 12'(frame_o), 12'd0);
    wait_frame();
    chk("mix_joy1", joy1_o, 12'hFDE);
    chk("mix_six1", 12'(six1_o), 12'd1);

    // Reset right after the step 5 tick of the following frame
    repeat (254 * TickDiv) @(posedge clk_i);
    #1;
    chk("pre_rst_six1", 12'(six1_o), 12'd1);
    res_n_i = 1'b0;
    #1;
    chk("mid_rst_joy1", joy1_o, 12'hFFF);
    chk("mid_rst_six1", 12'(six1_o), 12'd0);
    chk("mid_rst_p7", 12'(joy_p7_o), 12'd1);
    chk("mid_rst_frame", 12'(frame_o), 12'd0);
    repeat (3) @(negedge clk_i);
    res_n_i = 1'b1;
    begin
      int c;
      c = 0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk_i);
        c = i;
        if (frame_o) break;
      end
      chk("restart_latency", 12'(c), 12'd32);
    end
    chk("restart_joy1", joy1_o, 12'hFFF);
    chk("restart_six1", 12'(six1_o), 12'd1);
    @(negedge clk_i);
    chk("frame_width", 12'(frame_o), 12'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
